// File: rtl/pipeline_pkg.sv
// Shared IF/ID types: default widths, the NOP encoding shown to decode when
// the buffer is empty, and the {instr, pc} packet stored per FIFO entry.
package pipeline_pkg;
  localparam int INSTR_W_DEF = 32;
  localparam int ADDR_W_DEF  = 64;
  localparam logic [31:0] NOP_INSTR = 32'hD503201F;

  typedef struct packed {
    logic [INSTR_W_DEF-1:0] instr;
    logic [ADDR_W_DEF-1:0]  pc;
  } fetch_packet_t;
endpackage

// File: rtl/fetch_buffer_storage.sv
// DEPTH-entry packet register file: one synchronous write port, one
// asynchronous read port. Contents are deliberately left unreset.
module fetch_buffer_storage
  import pipeline_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [PTR_W-1:0]   wr_ptr,
  input  fetch_packet_t      wr_data,
  input  logic [PTR_W-1:0]   rd_ptr,
  output fetch_packet_t      rd_data
);
  fetch_packet_t mem_q [DEPTH];
  fetch_packet_t mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_ptr] = wr_data;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data = mem_q[rd_ptr];
endmodule

// File: rtl/fetch_decode_buffer.sv
// Elastic IF/ID FIFO: holds fetched {instr, pc} beats across decode stalls and
// discards everything in flight on a taken-branch flush.
module fetch_decode_buffer
  import pipeline_pkg::*;
#(
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DEPTH   = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [INSTR_W-1:0]         instruction_Fetch,
  input  logic [ADDR_W-1:0]          programCounter_Fetch,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INSTR_W-1:0]         instruction_Decode,
  output logic [ADDR_W-1:0]          programCounter_Decode,
  output logic [$clog2(DEPTH):0]     count,
  output logic [15:0]                flush_drops
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [15:0]      drops_q, drops_d;
  logic [16:0]      drop_sum;
  logic             push, pop;
  fetch_packet_t    wr_pkt, rd_pkt;

  // in_ready depends only on registered count, never on out_ready
  assign in_ready  = (count_q != FULL);
  assign out_valid = (count_q != '0);

  always_comb begin
    push     = in_valid & in_ready & ~flush;
    pop      = out_valid & out_ready & ~flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    drops_d  = drops_q;
    drop_sum = 17'(drops_q) + 17'(count_q) + 17'(in_valid & in_ready);
    if (flush) begin
      count_d  = '0;
      rd_ptr_d = wr_ptr_q;
      drops_d  = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drops_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drops_q  <= drops_d;
    end
  end

  always_comb begin
    wr_pkt       = '0;
    wr_pkt.instr = instruction_Fetch;
    wr_pkt.pc    = programCounter_Fetch;
  end

  fetch_buffer_storage #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_storage (
    .clk     (clk),
    .wr_en   (push),
    .wr_ptr  (wr_ptr_q),
    .wr_data (wr_pkt),
    .rd_ptr  (rd_ptr_q),
    .rd_data (rd_pkt)
  );

  assign instruction_Decode    = out_valid ? rd_pkt.instr : NOP_INSTR;
  assign programCounter_Decode = out_valid ? rd_pkt.pc : '0;
  assign count                 = count_q;
  assign flush_drops           = drops_q;
endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Directed bench for fetch_decode_buffer: stimulus process pushes expected
// packets into a scoreboard queue, a negedge monitor pops and compares them.
module tb_fetch_decode_buffer;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] instr_f, instr_d;
  logic [63:0] pc_f, pc_d;
  logic [1:0]  count;
  logic [15:0] flush_drops;

  int checks = 0;
  int failures = 0;
  logic [95:0] sb [$];

  fetch_decode_buffer #(.INSTR_W(32), .ADDR_W(64), .DEPTH(2)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .in_valid              (in_valid),
    .in_ready              (in_ready),
    .instruction_Fetch     (instr_f),
    .programCounter_Fetch  (pc_f),
    .flush                 (flush),
    .out_valid             (out_valid),
    .out_ready             (out_ready),
    .instruction_Decode    (instr_d),
    .programCounter_Decode (pc_d),
    .count                 (count),
    .flush_drops           (flush_drops)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [63:0] pc);
    pc_f    = pc;
    instr_f = 32'hE000_0000 ^ pc[31:0];
  endtask

  // Scoreboard monitor: pop/compare first, then record any accepted beat.
  always @(negedge clk) begin
    if (!reset) begin
      sb.delete();
    end else begin
      chk("out_valid_vs_model", {63'd0, out_valid}, {63'd0, sb.size() != 0});
      if (out_valid && out_ready && !flush) begin
        if (sb.size() == 0) begin
          chk("pop_without_entry", 64'd1, 64'd0);
        end else begin
          chk("head_pc", pc_d, sb[0][63:0]);
          chk("head_instr", {32'd0, instr_d}, {32'd0, sb[0][95:64]});
          void'(sb.pop_front());
        end
      end
      if (flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back({instr_f, pc_f});
    end
  end

  initial begin
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    drive(64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_count", {62'd0, count}, 64'd0);
    chk("rst_instr_nop", {32'd0, instr_d}, 64'hD503201F);
    chk("rst_pc", pc_d, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_drops", {48'd0, flush_drops}, 64'd0);
    reset = 1'b1;
    step();

    // Streaming: one beat per cycle, occupancy stays at 1
    in_valid = 1'b1; out_ready = 1'b1; drive(64'd0);
    step();
    chk("stream_first_pc", pc_d, 64'd0);
    chk("stream_first_count", {62'd0, count}, 64'd1);
    for (int i = 1; i < 8; i++) begin
      drive(64'(4 * i));
      step();
      chk("stream_pc", pc_d, 64'(4 * i));
      chk("stream_count", {62'd0, count}, 64'd1);
    end
    in_valid = 1'b0;
    step();
    chk("stream_drain_count", {62'd0, count}, 64'd0);
    chk("stream_drain_nop", {32'd0, instr_d}, 64'hD503201F);

    // Backpressure, then full with simultaneous pop
    out_ready = 1'b0; in_valid = 1'b1; drive(64'h10);
    step();
    drive(64'h14);
    step();
    chk("bp_count_full", {62'd0, count}, 64'd2);
    chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
    drive(64'h18);
    step();
    chk("bp_refused_count", {62'd0, count}, 64'd2);
    chk("bp_head_held", pc_d, 64'h10);
    out_ready = 1'b1;
    step();
    chk("full_pop_count", {62'd0, count}, 64'd1);
    chk("full_pop_head", pc_d, 64'h14);
    step();
    chk("bp_third_count", {62'd0, count}, 64'd1);
    chk("bp_third_head", pc_d, 64'h18);
    in_valid = 1'b0;
    step();
    chk("bp_drain_count", {62'd0, count}, 64'd0);

    // Flush while full with a beat offered (refused, since full): drops 2
    out_ready = 1'b0; in_valid = 1'b1; drive(64'h20);
    step();
    drive(64'h24);
    step();
    chk("fl_pre_count", {62'd0, count}, 64'd2);
    drive(64'h28); flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_count", {62'd0, count}, 64'd0);
    chk("fl_out_valid", {63'd0, out_valid}, 64'd0);
    chk("fl_drops_full", {48'd0, flush_drops}, 64'd2);
    drive(64'h100);
    step();
    chk("fl_target_pc", pc_d, 64'h100);
    chk("fl_target_count", {62'd0, count}, 64'd1);
    // count=1 and an accepted-if-not-flushed beat: drops += 2
    drive(64'h104); flush = 1'b1;
    step();
    chk("fl_drops_partial", {48'd0, flush_drops}, 64'd4);
    chk("fl_partial_count", {62'd0, count}, 64'd0);
    in_valid = 1'b0;
    step();
    chk("fl_empty_noop", {48'd0, flush_drops}, 64'd4);

    // Saturation: each flush+valid on empty adds one
    in_valid = 1'b1;
    repeat (65540) step();
    chk("fl_drops_sat", {48'd0, flush_drops}, 64'hFFFF);
    flush = 1'b0; in_valid = 1'b0;
    step();

    // Async reset between clock edges with two entries held
    out_ready = 1'b0; in_valid = 1'b1; drive(64'h200);
    step();
    drive(64'h204);
    step();
    in_valid = 1'b0;
    chk("ar_pre_count", {62'd0, count}, 64'd2);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_count", {62'd0, count}, 64'd0);
    chk("ar_out_valid", {63'd0, out_valid}, 64'd0);
    chk("ar_drops", {48'd0, flush_drops}, 64'd0);
    chk("ar_nop", {32'd0, instr_d}, 64'hD503201F);
    step();
    reset = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
